eei_dispatch: RTL and testbench

- Sequencer between the core's EEI request port and up to 16 custom execution units (fast GPIO, snapshot registers, future units).
- Decodes {eei_ext, eei_funct3} into a unit slot and drives a level request/ack handshake to that unit.
- Guards every transaction with a watchdog and returns a registered single-rd response to the core.
- Unmapped slots and hung units complete with eei_error instead of stalling the pipeline.

---
 rtl/eei_dispatch_pkg.sv | 17 +
 rtl/eei_wdog.sv | 47 ++++
 rtl/eei_dispatch.sv | 119 +++++++++++
 tb/tb_eei_dispatch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/eei_dispatch_pkg.sv
// Shared slot map, FSM encoding and sizing helpers for the EEI dispatcher.
package eei_dispatch_pkg;

  localparam int EEI_SLOT_NUM = 16;
  localparam int EEI_SLOT_W   = 4;

  localparam logic [EEI_SLOT_W-1:0] SLOT_FGPIO = 4'b0000;
  localparam logic [EEI_SLOT_W-1:0] SLOT_SREG  = 4'b1000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} eei_disp_state_e;

  // A disabled watchdog (0 cycles) still needs a legal one-bit counter.
  function automatic int wdog_width(input int cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/eei_wdog.sv
// Per-transaction watchdog: counts WAIT cycles, flags expiry in the last allowed cycle,
// and keeps a saturating expiry count plus a sticky flag. No backpressure; expiry is combinational.
module eei_wdog
  import eei_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run,
  input  logic             fire,
  output logic             expire,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             timeout_flag
);

  localparam int WD_W = wdog_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (!run) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign expire = run && (TIMEOUT_CYC != 0) && (wd_cnt == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_cnt  <= '0;
      timeout_flag <= 1'b0;
    end else if (fire) begin
      timeout_flag <= 1'b1;
      if (timeout_cnt != '1) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/eei_dispatch.sv
// Routes EEI requests to one of NUM_UNITS units over a level req/ack handshake and returns a
// registered response; latency 1 (unmapped), 2 + unit wait, or TIMEOUT_CYC + 1 on watchdog expiry.
module eei_dispatch
  import eei_dispatch_pkg::*;
#(
  parameter int NUM_UNITS   = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    eei_req,
  input  logic                    eei_ext,
  input  logic [2:0]              eei_funct3,
  output logic                    eei_ack,
  output logic                    eei_error,
  output logic [31:0]             eei_rd_val,
  output logic                    eei_busy,
  output logic [NUM_UNITS-1:0]    unit_req,
  input  logic [NUM_UNITS-1:0]    unit_ack,
  input  logic [NUM_UNITS-1:0]    unit_error,
  input  logic [NUM_UNITS*32-1:0] unit_rd_val,
  output logic [CNT_W-1:0]        timeout_cnt,
  output logic                    timeout_flag
);

  eei_disp_state_e       state, state_nxt;
  logic [EEI_SLOT_W-1:0] slot, sel;
  logic                  mapped;
  logic                  sel_ack, sel_err;
  logic [31:0]           sel_rd;
  logic                  expire, fire;
  logic                  ld_err;
  logic [31:0]           ld_rd;

  assign slot   = {eei_ext, eei_funct3};
  assign mapped = ({1'b0, slot} < (EEI_SLOT_W + 1)'(NUM_UNITS));

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rd  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel == EEI_SLOT_W'(i)) begin
        sel_ack = unit_ack[i];
        sel_err = unit_error[i];
        sel_rd  = unit_rd_val[i*32 +: 32];
      end
    end
  end

  // A flush or a same-cycle unit ack both suppress the timeout event.
  assign fire = (state == WAIT) && eei_req && !sel_ack && expire;

  eei_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wdog (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run          (state == WAIT),
    .fire         (fire),
    .expire       (expire),
    .timeout_cnt  (timeout_cnt),
    .timeout_flag (timeout_flag)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (eei_req) state_nxt = mapped ? WAIT : RESP;
      WAIT: begin
        if (!eei_req)               state_nxt = IDLE;
        else if (sel_ack || expire) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unit_req = '0;
    eei_busy = (state != IDLE);
    ld_err   = 1'b1;
    ld_rd    = '0;
    if (state == WAIT) begin
      unit_req = NUM_UNITS'(1) << sel;
      if (sel_ack) begin
        ld_err = sel_err;
        ld_rd  = sel_rd;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel        <= '0;
      eei_ack    <= 1'b0;
      eei_error  <= 1'b0;
      eei_rd_val <= '0;
    end else begin
      if (state == IDLE && eei_req && mapped) begin
        sel <= slot;
      end
      eei_ack    <= (state_nxt == RESP);
      eei_error  <= (state_nxt == RESP) && ld_err;
      eei_rd_val <= (state_nxt == RESP) ? ld_rd : 32'h0;
    end
  end

endmodule

// File: tb/tb_eei_dispatch.sv
// Directed bench for eei_dispatch with NUM_UNITS=2, TIMEOUT_CYC=4, CNT_W=2.
module tb_eei_dispatch;
  import eei_dispatch_pkg::*;

  localparam int NU = 2;
  localparam int TO = 4;
  localparam int CW = 2;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           eei_req;
  logic           eei_ext;
  logic [2:0]     eei_funct3;
  logic           eei_ack;
  logic           eei_error;
  logic [31:0]    eei_rd_val;
  logic           eei_busy;
  logic [NU-1:0]  unit_req;
  logic [NU-1:0]  unit_ack;
  logic [NU-1:0]  unit_error;
  logic [NU*32-1:0] unit_rd_val;
  logic [CW-1:0]  timeout_cnt;
  logic           timeout_flag;

  int n_cmp = 0;
  int n_bad = 0;

  eei_dispatch #(.NUM_UNITS(NU), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .eei_req      (eei_req),
    .eei_ext      (eei_ext),
    .eei_funct3   (eei_funct3),
    .eei_ack      (eei_ack),
    .eei_error    (eei_error),
    .eei_rd_val   (eei_rd_val),
    .eei_busy     (eei_busy),
    .unit_req     (unit_req),
    .unit_ack     (unit_ack),
    .unit_error   (unit_error),
    .unit_rd_val  (unit_rd_val),
    .timeout_cnt  (timeout_cnt),
    .timeout_flag (timeout_flag)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  slot;
    int          ack_at;   // WAIT cycle index (0-based) of the unit ack; -1 never acks
    logic        uerr;
    logic [31:0] urd;
    logic        stray;    // non-selected unit acks while the selected one is pending
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_reqc;
    logic [1:0]  exp_mask;
    int          exp_cnt;
    logic        exp_flag;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one request starting at the next IDLE cycle, plays the unit side, and stops on eei_ack.
  task automatic txn(input logic [3:0] s, input int ack_at, input logic uerr,
                     input logic [31:0] urd, input logic stray,
                     output int lat, output logic err, output logic [31:0] rd,
                     output int reqc, output logic [1:0] mask, output int busyc,
                     output int leak);
    int nwait;
    lat = -1; err = 1'b0; rd = '0; reqc = 0; mask = '0; busyc = 0; leak = 0; nwait = 0;
    @(negedge clk_i);
    {eei_ext, eei_funct3} = s;
    eei_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        if (eei_busy) busyc++;
        if (eei_ack) begin
          lat = c; err = eei_error; rd = eei_rd_val;
          break;
        end
        if (eei_rd_val != '0 || eei_error) leak++;
        unit_ack = '0; unit_error = '0; unit_rd_val = '0;
        if (unit_req != '0) begin
          reqc++;
          mask = mask | unit_req;
          if (nwait == ack_at) begin
            unit_ack   = unit_req;
            unit_error = uerr ? unit_req : '0;
            for (int i = 0; i < NU; i++)
              if (unit_req[i]) unit_rd_val[i*32 +: 32] = urd;
          end else if (stray) begin
            unit_ack    = ~unit_req;
            unit_error  = ~unit_req;
            unit_rd_val = '1;
          end
          nwait++;
        end
      end
      @(negedge clk_i);
    end
    eei_req = 1'b0;
    unit_ack = '0; unit_error = '0; unit_rd_val = '0;
  endtask

  initial begin
    int lat, reqc, busyc, leak, acks;
    logic err;
    logic [31:0] rd;
    logic [1:0] mask;

    vt[0] = '{4'd1,  0, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'hDEADBEEF, 1, 2'b10, 0, 1'b0};
    vt[1] = '{4'd13, -1, 1'b0, 32'h0,       1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 1'b0};
    vt[2] = '{4'd0,  2, 1'b1, 32'h12345678, 1'b1, 4, 1'b1, 32'h12345678, 3, 2'b01, 0, 1'b0};
    vt[3] = '{4'd0,  3, 1'b0, 32'hA5A5A5A5, 1'b0, 5, 1'b0, 32'hA5A5A5A5, 4, 2'b01, 0, 1'b0};
    vt[4] = '{SLOT_SREG, -1, 1'b0, 32'h0,  1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 1'b0};
    vt[5] = '{4'd2,  -1, 1'b0, 32'h0,       1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 1'b0};
    vt[6] = '{4'd1,  1, 1'b1, 32'hFFFFFFFF, 1'b1, 3, 1'b1, 32'hFFFFFFFF, 2, 2'b10, 0, 1'b0};
    vt[7] = '{SLOT_FGPIO, -1, 1'b0, 32'h0, 1'b0, 5, 1'b1, 32'h0,        4, 2'b01, 1, 1'b1};
    vt[8] = '{4'd1,  0, 1'b0, 32'h00000001, 1'b0, 2, 1'b0, 32'h00000001, 1, 2'b10, 1, 1'b1};

    rst_i = 1'b1; eei_req = 1'b0; eei_ext = 1'b0; eei_funct3 = '0;
    unit_ack = '0; unit_error = '0; unit_rd_val = '0;
    repeat (2) @(negedge clk_i);
    chk("rst.ack",  32'(eei_ack), 32'h0);
    chk("rst.err",  32'(eei_error), 32'h0);
    chk("rst.rd",   eei_rd_val, 32'h0);
    chk("rst.busy", 32'(eei_busy), 32'h0);
    chk("rst.ureq", 32'(unit_req), 32'h0);
    chk("rst.cnt",  32'(timeout_cnt), 32'h0);
    chk("rst.flag", 32'(timeout_flag), 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      txn(vt[i].slot, vt[i].ack_at, vt[i].uerr, vt[i].urd, vt[i].stray,
          lat, err, rd, reqc, mask, busyc, leak);
      chk($sformatf("v%0d.lat", i),  32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d.err", i),  32'(err), 32'(vt[i].exp_err));
      chk($sformatf("v%0d.rd", i),   rd, vt[i].exp_rd);
      chk($sformatf("v%0d.reqc", i), 32'(reqc), 32'(vt[i].exp_reqc));
      chk($sformatf("v%0d.mask", i), 32'(mask), 32'(vt[i].exp_mask));
      chk($sformatf("v%0d.busy", i), 32'(busyc), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d.leak", i), 32'(leak), 32'h0);
      chk($sformatf("v%0d.cnt", i),  32'(timeout_cnt), 32'(vt[i].exp_cnt));
      chk($sformatf("v%0d.flag", i), 32'(timeout_flag), 32'(vt[i].exp_flag));
    end

    // Core flush after two WAIT cycles.
    @(negedge clk_i);
    {eei_ext, eei_funct3} = 4'd0;
    eei_req = 1'b1;
    @(negedge clk_i);
    chk("fl.ureq1", 32'(unit_req), 32'h1);
    @(negedge clk_i);
    chk("fl.ureq2", 32'(unit_req), 32'h1);
    eei_req = 1'b0;
    @(negedge clk_i);
    chk("fl.ureq3", 32'(unit_req), 32'h0);
    chk("fl.busy",  32'(eei_busy), 32'h0);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (eei_ack) acks++;
      @(negedge clk_i);
    end
    chk("fl.noack", 32'(acks), 32'h0);
    chk("fl.cnt",   32'(timeout_cnt), 32'h1);
    txn(4'd0, 1, 1'b0, 32'h0BADF00D, 1'b0, lat, err, rd, reqc, mask, busyc, leak);
    chk("fl.next.lat", 32'(lat), 32'd3);
    chk("fl.next.err", 32'(err), 32'h0);
    chk("fl.next.rd",  rd, 32'h0BADF00D);

    // Four more expiries: 5 in total saturate the 2-bit counter at 3.
    for (int k = 0; k < 4; k++) begin
      txn(4'd0, -1, 1'b0, 32'h0, 1'b0, lat, err, rd, reqc, mask, busyc, leak);
      chk($sformatf("sat%0d.lat", k), 32'(lat), 32'd5);
      chk($sformatf("sat%0d.err", k), 32'(err), 32'h1);
      chk($sformatf("sat%0d.cnt", k), 32'(timeout_cnt), 32'((k + 2 > 3) ? 3 : k + 2));
    end
    chk("sat.flag", 32'(timeout_flag), 32'h1);

    // Reset asserted between clock edges while in WAIT.
    @(negedge clk_i);
    {eei_ext, eei_funct3} = 4'd1;
    eei_req = 1'b1;
    @(negedge clk_i);
    chk("ar.ureq.pre", 32'(unit_req), 32'h2);
    #2 rst_i = 1'b1;
    #1;
    chk("ar.ureq", 32'(unit_req), 32'h0);
    chk("ar.busy", 32'(eei_busy), 32'h0);
    chk("ar.cnt",  32'(timeout_cnt), 32'h0);
    chk("ar.flag", 32'(timeout_flag), 32'h0);
    @(negedge clk_i);
    eei_req = 1'b0;
    rst_i = 1'b0;
    txn(4'd1, 0, 1'b0, 32'hCAFEF00D, 1'b0, lat, err, rd, reqc, mask, busyc, leak);
    chk("ar.next.lat", 32'(lat), 32'd2);
    chk("ar.next.rd",  rd, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
